// File: rtl/mips_pkg.sv
// Shared definitions for the syscall unit: service codes, decimal power table and FSM states.
package mips_pkg;

    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;

    // POW10[i] = 10^i
    localparam logic [31:0] POW10 [0:9] = '{
        32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000, 32'd100000, 32'd1000000,
        32'd10000000, 32'd100000000, 32'd1000000000
    };

    typedef enum logic [2:0] {
        StIdle,
        StDispatch,
        StInt,
        StChar,
        StStrReq,
        StStrWait,
        StStrEmit,
        StHalted
    } sys_state_e;

    typedef enum logic [2:0] {
        FmtIdle,
        FmtSign,
        FmtDigit,
        FmtEmit,
        FmtHexPfx,
        FmtHexNib
    } fmt_state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/syscall_unit_if.sv
// Data-memory read port and console byte stream of the syscall unit.
interface syscall_unit_if;

    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    modport master (
        output mem_rd_en, mem_addr, out_valid, out_data,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, out_valid, out_data,
        output mem_rdata, out_ready
    );

endinterface

// File: rtl/syscall_int_fmt.sv
// Serialises a 32-bit value as signed decimal ASCII (or "0x" + 8 hex digits) over valid/ready.
module syscall_int_fmt
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hex,
    input  logic [31:0] value,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        done
);

    fmt_state_e  state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  digit_q, digit_d;
    logic        started_q, started_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FmtIdle;
            mag_q     <= '0;
            idx_q     <= '0;
            digit_q   <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            idx_q     <= idx_d;
            digit_q   <= digit_d;
            started_q <= started_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        idx_d     = idx_q;
        digit_d   = digit_q;
        started_d = started_q;
        out_valid = 1'b0;
        out_data  = 8'h00;
        done      = 1'b0;
        unique case (state_q)
            FmtIdle: begin
                if (start) begin
                    digit_d   = 4'd0;
                    started_d = 1'b0;
                    if (hex) begin
                        mag_d   = value;
                        idx_d   = 4'd7;
                        state_d = FmtHexPfx;
                    end else begin
                        // Two's-complement negate also covers 0x80000000 as unsigned 2^31
                        mag_d   = value[31] ? (~value + 32'd1) : value;
                        idx_d   = 4'd9;
                        state_d = value[31] ? FmtSign : FmtDigit;
                    end
                end
            end
            FmtSign: begin
                out_valid = 1'b1;
                out_data  = 8'h2D;
                if (out_ready) state_d = FmtDigit;
            end
            FmtDigit: begin
                if (mag_q >= POW10[idx_q]) begin
                    mag_d   = mag_q - POW10[idx_q];
                    digit_d = digit_q + 4'd1;
                end else if (digit_q != 4'd0 || started_q || idx_q == 4'd0) begin
                    state_d = FmtEmit;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            FmtEmit: begin
                out_valid = 1'b1;
                out_data  = 8'h30 + {4'h0, digit_q};
                if (out_ready) begin
                    started_d = 1'b1;
                    digit_d   = 4'd0;
                    if (idx_q == 4'd0) begin
                        done    = 1'b1;
                        state_d = FmtIdle;
                    end else begin
                        idx_d   = idx_q - 4'd1;
                        state_d = FmtDigit;
                    end
                end
            end
            FmtHexPfx: begin
                out_valid = 1'b1;
                out_data  = digit_q[0] ? 8'h78 : 8'h30;
                if (out_ready) begin
                    if (digit_q[0]) state_d = FmtHexNib;
                    else            digit_d = 4'd1;
                end
            end
            FmtHexNib: begin
                out_valid = 1'b1;
                out_data  = hex_char(mag_q[31:28]);
                if (out_ready) begin
                    mag_d = {mag_q[27:0], 4'h0};
                    if (idx_q == 4'd0) begin
                        done    = 1'b1;
                        state_d = FmtIdle;
                    end else begin
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = FmtIdle;
        endcase
    end

endmodule

// File: rtl/syscall_unit.sv
// SYSCALL service unit: prints int/char/string to a console stream, halts on exit.
// Define SYSCALL_HEX_EN to add service 34 (print "0x" + 8 uppercase hex digits).
module syscall_unit
    import mips_pkg::*;
#(
    parameter int unsigned MAX_STR_LEN = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               syscall,
    input  logic [31:0]        sys_call_reg,
    input  logic [31:0]        std_out_address,
    syscall_unit_if.master     bus,
    output logic               stall,
    output logic               halted,
    output logic               bad_call
);

    localparam int unsigned CntW = $clog2(MAX_STR_LEN + 1);

    sys_state_e      state_q, state_d;
    logic [31:0]     v0_q, v0_d;
    logic [31:0]     a0_q, a0_d;
    logic [31:0]     word_q, word_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      str_byte;

    logic       fmt_start, fmt_hex, fmt_valid, fmt_ready, fmt_done;
    logic [7:0] fmt_data;

    syscall_int_fmt u_int_fmt (
        .clk       (clk),
        .reset     (reset),
        .start     (fmt_start),
        .hex       (fmt_hex),
        .value     (a0_q),
        .out_valid (fmt_valid),
        .out_data  (fmt_data),
        .out_ready (fmt_ready),
        .done      (fmt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            v0_q    <= '0;
            a0_q    <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            a0_q    <= a0_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        unique case (a0_q[1:0])
            2'd0:    str_byte = word_q[7:0];
            2'd1:    str_byte = word_q[15:8];
            2'd2:    str_byte = word_q[23:16];
            default: str_byte = word_q[31:24];
        endcase
    end

    assign bus.mem_addr = {a0_q[31:2], 2'b00};
    assign stall        = (state_q != StIdle) | syscall;
    assign halted       = (state_q == StHalted);

    always_comb begin
        state_d       = state_q;
        v0_d          = v0_q;
        a0_d          = a0_q;
        word_d        = word_q;
        cnt_d         = cnt_q;
        bus.mem_rd_en = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        bad_call      = 1'b0;
        fmt_start     = 1'b0;
        fmt_hex       = 1'b0;
        fmt_ready     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (syscall) begin
                    v0_d    = sys_call_reg;
                    a0_d    = std_out_address;
                    cnt_d   = '0;
                    state_d = StDispatch;
                end
            end
            StDispatch: begin
                case (v0_q)
                    SYS_PRINT_INT: begin
                        fmt_start = 1'b1;
                        state_d   = StInt;
                    end
                    SYS_PRINT_CHAR: state_d = StChar;
                    SYS_PRINT_STR:  state_d = StStrReq;
                    SYS_EXIT:       state_d = StHalted;
`ifdef SYSCALL_HEX_EN
                    SYS_PRINT_HEX: begin
                        fmt_start = 1'b1;
                        fmt_hex   = 1'b1;
                        state_d   = StInt;
                    end
`endif
                    default: begin
                        bad_call = 1'b1;
                        state_d  = StIdle;
                    end
                endcase
            end
            StInt: begin
                bus.out_valid = fmt_valid;
                bus.out_data  = fmt_data;
                fmt_ready     = bus.out_ready;
                if (fmt_done) state_d = StIdle;
            end
            StChar: begin
                bus.out_valid = 1'b1;
                bus.out_data  = a0_q[7:0];
                if (bus.out_ready) state_d = StIdle;
            end
            StStrReq: begin
                bus.mem_rd_en = 1'b1;
                state_d       = StStrWait;
            end
            StStrWait: begin
                word_d  = bus.mem_rdata;
                state_d = StStrEmit;
            end
            StStrEmit: begin
                if (str_byte == 8'h00) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(MAX_STR_LEN)) begin
                    bad_call = 1'b1;
                    state_d  = StIdle;
                end else begin
                    bus.out_valid = 1'b1;
                    bus.out_data  = str_byte;
                    if (bus.out_ready) begin
                        a0_d  = a0_q + 32'd1;
                        cnt_d = cnt_q + CntW'(1);
                        // Latched word exhausted after lane 3
                        if (a0_q[1:0] == 2'd3) state_d = StStrReq;
                    end
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Scoreboard bench for syscall_unit: expected console bytes queued per call, popped on transfer.
module tb_syscall_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        syscall;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        stall;
    logic        halted;
    logic        bad_call;

    syscall_unit_if bus ();

    syscall_unit #(.MAX_STR_LEN(256)) dut (
        .clk             (clk),
        .reset           (reset),
        .syscall         (syscall),
        .sys_call_reg    (v0),
        .std_out_address (a0),
        .bus             (bus),
        .stall           (stall),
        .halted          (halted),
        .bad_call        (bad_call)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end

    logic [7:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;
    int n_bad    = 0;
    int n_reads  = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
                else                   check("byte", {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
            end
            if (bad_call)      n_bad++;
            if (bus.mem_rd_en) n_reads++;
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        syscall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (stall && cyc < 5000) begin
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.out_ready = 1'b1;
        check({tag, "_done"}, {31'h0, stall}, 32'd0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_call(input logic [31:0] code, input logic [31:0] arg, input string tag);
        v0      = code;
        a0      = arg;
        syscall = 1'b1;
        #1;
        check({tag, "_stall0"}, {31'h0, stall}, 32'd1);
        @(posedge clk);
        #1;
        syscall = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        syscall       = 1'b0;
        v0            = '0;
        a0            = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[64] = 32'h6C6C6548;
        mem[65] = 32'h0000006F;
        for (int i = 128; i < 200; i++) mem[i] = 32'h41424344;
        do_reset();

        check("rst_stall",  {31'h0, stall},         32'd0);
        check("rst_halted", {31'h0, halted},        32'd0);
        check("rst_bad",    {31'h0, bad_call},      32'd0);
        check("rst_valid",  {31'h0, bus.out_valid}, 32'd0);
        check("rst_data",   {24'h0, bus.out_data},  32'd0);
        check("rst_rd_en",  {31'h0, bus.mem_rd_en}, 32'd0);

        push_str("-305");
        do_call(SYS_PRINT_INT, 32'hFFFF_FECF, "int_neg");
        push_str("0");
        do_call(SYS_PRINT_INT, 32'd0, "int_zero");
        push_str("-2147483648");
        do_call(SYS_PRINT_INT, 32'h8000_0000, "int_min");
        push_str("4294");
        do_call(SYS_PRINT_INT, 32'd4294, "int_pos");

        n_reads = 0;
        push_str("Hello");
        do_call(SYS_PRINT_STR, 32'h100, "str_hello");
        check("str_hello_reads", 32'(n_reads), 32'd2);
        n_reads = 0;
        push_str("ello");
        do_call(SYS_PRINT_STR, 32'h101, "str_ello");
        check("str_ello_reads", 32'(n_reads), 32'd2);

        rand_ready = 1'b1;
        push_str("Hello");
        do_call(SYS_PRINT_STR, 32'h100, "str_bp");
        push_str("-98765");
        do_call(SYS_PRINT_INT, -32'sd98765, "int_bp");
        rand_ready = 1'b0;

        // Char held under backpressure, transfers on first ready cycle
        bus.out_ready = 1'b0;
        v0 = SYS_PRINT_CHAR;
        a0 = 32'h41;
        syscall = 1'b1;
        @(posedge clk);
        #1;
        syscall = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'h0, bus.out_valid}, 32'd1);
            check("hold_data",  {24'h0, bus.out_data},  32'h41);
            check("hold_stall", {31'h0, stall},         32'd1);
            @(posedge clk);
            #1;
        end
        exp_q.push_back(8'h41);
        bus.out_ready = 1'b1;
        wait_idle("char");

        n_bad = 0;
        do_call(32'd7, 32'h1234, "unknown");
        check("unknown_bad", 32'(n_bad), 32'd1);

        n_bad = 0;
`ifdef SYSCALL_HEX_EN
        push_str("0xDEADBEEF");
        do_call(SYS_PRINT_HEX, 32'hDEAD_BEEF, "hex");
        check("hex_bad", 32'(n_bad), 32'd0);
`else
        do_call(SYS_PRINT_HEX, 32'hDEAD_BEEF, "hex");
        check("hex_bad", 32'(n_bad), 32'd1);
`endif

        // 256 bytes emitted, then truncation flagged
        n_bad = 0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = mem[(32'h200 + i) >> 2];
            exp_q.push_back(w[8*(i%4) +: 8]);
        end
        do_call(SYS_PRINT_STR, 32'h200, "trunc");
        check("trunc_bad", 32'(n_bad), 32'd1);

        // Reset in the middle of a string
        for (int i = 0; i < 256; i++) exp_q.push_back(8'h44 - 8'(i % 4));
        v0 = SYS_PRINT_STR;
        a0 = 32'h200;
        syscall = 1'b1;
        @(posedge clk);
        #1;
        syscall = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", {31'h0, bus.out_valid}, 32'd0);
        check("midrst_rd_en", {31'h0, bus.mem_rd_en}, 32'd0);
        check("midrst_stall", {31'h0, stall},         32'd0);
        reset = 1'b0;
        exp_q.delete();

        v0 = SYS_EXIT;
        a0 = 32'h0;
        syscall = 1'b1;
        @(posedge clk);
        #1;
        syscall = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("halt_halted", {31'h0, halted}, 32'd1);
        check("halt_stall",  {31'h0, stall},  32'd1);
        v0 = SYS_PRINT_CHAR;
        a0 = 32'h5A;
        syscall = 1'b1;
        @(posedge clk);
        #1;
        syscall = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("halt_still",  {31'h0, halted},        32'd1);
        check("halt_quiet",  {31'h0, bus.out_valid}, 32'd0);
        check("halt_stall2", {31'h0, stall},         32'd1);
        do_reset();
        check("unhalt_halted", {31'h0, halted}, 32'd0);
        check("unhalt_stall",  {31'h0, stall},  32'd0);

        push_str("7");
        do_call(SYS_PRINT_INT, 32'd7, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
